// File: rtl/baby_core_p.sv
// baby_core_p: parametrised SSEM (Manchester Baby) core with a continuously clocked run/halt/single-step FSM.
// Optional debug taps (A, CI, PI, retire pulse and counter) are enabled by defining BABY_DEBUG_EN.
module baby_core_p #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              sys_clk_i,
    input  logic              rst_ni,
    input  logic              hlt_ext_i,
    input  logic              step_i,
    input  logic [WORD_W-1:0] ram_data_i,
    output logic [WORD_W-1:0] ram_data_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_rw_en_o,
    output logic              stop_lamp_o,
    output logic              hlt_status_o
`ifdef BABY_DEBUG_EN
    ,
    output logic [WORD_W-1:0] acc_o,
    output logic [ADDR_W-1:0] ci_o,
    output logic [WORD_W-1:0] pi_o,
    output logic              retire_o,
    output logic [15:0]       retire_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_INC,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_HALT,
        S_STOP
    } state_t;

    typedef enum logic [2:0] {
        F_JMP  = 3'd0,
        F_JRP  = 3'd1,
        F_LDN  = 3'd2,
        F_STO  = 3'd3,
        F_SUB  = 3'd4,
        F_SUB2 = 3'd5,
        F_CMP  = 3'd6,
        F_STP  = 3'd7
    } func_t;

    localparam logic [ADDR_W-1:0] CI_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]   ci_q, ci_d;
    logic [ADDR_W-1:0]   piLine_q, piLine_d;
    func_t               piFunc_q, piFunc_d;
    logic                stepPrev_q;
    logic                singleStep_q, singleStep_d;

    logic                stepRise;
    logic                writeEn;
    logic                retire;
    logic [ADDR_W-1:0]   addrNext;
    logic [ADDR_W-1:0]   memLine;

    assign stepRise = step_i & ~stepPrev_q;
    assign memLine  = ram_data_i[ADDR_W-1:0];

    // Sequencer: five cycles per instruction, halt/step decisions only at the EXEC boundary.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        ci_d         = ci_q;
        piLine_d     = piLine_q;
        piFunc_d     = piFunc_q;
        singleStep_d = singleStep_q;
        addrNext     = '0;
        writeEn      = 1'b0;
        retire       = 1'b0;
        stop_lamp_o  = 1'b0;
        hlt_status_o = 1'b0;

        case (state_q)
            S_INC: begin
                ci_d    = ci_q + CI_ONE;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                addrNext = ci_q;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                piLine_d = ram_data_i[ADDR_W-1:0];
                piFunc_d = func_t'(ram_data_i[15:13]);
                state_d  = S_OPERAND;
            end
            S_OPERAND: begin
                addrNext = piLine_q;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                addrNext     = piLine_q;
                retire       = 1'b1;
                singleStep_d = 1'b0;
                case (piFunc_q)
                    F_JMP:         ci_d = memLine;
                    F_JRP:         ci_d = ci_q + memLine;
                    F_LDN:         acc_d = -ram_data_i;
                    F_STO:         writeEn = 1'b1;
                    F_SUB, F_SUB2: acc_d = acc_q - ram_data_i;
                    F_CMP: begin
                        if (acc_q[WORD_W-1]) begin
                            ci_d = ci_q + CI_ONE;
                        end
                    end
                    default: ;
                endcase
                if (piFunc_q == F_STP) begin
                    state_d = S_STOP;
                end else if (hlt_ext_i || singleStep_q) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_INC;
                end
            end
            S_HALT: begin
                hlt_status_o = 1'b1;
                if (!hlt_ext_i) begin
                    state_d = S_INC;
                end else if (stepRise) begin
                    singleStep_d = 1'b1;
                    state_d      = S_INC;
                end
            end
            S_STOP: begin
                stop_lamp_o = 1'b1;
            end
            default: begin
                state_d = S_INC;
            end
        endcase
    end

    // A write in flight is suppressed as soon as reset is asserted, so it never commits.
    assign ram_addr_o  = addrNext;
    assign ram_rw_en_o = writeEn & rst_ni;
    assign ram_data_o  = (writeEn & rst_ni) ? acc_q : '0;

    always_ff @(posedge sys_clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_INC;
            acc_q        <= '0;
            ci_q         <= '0;
            piLine_q     <= '0;
            piFunc_q     <= F_JMP;
            stepPrev_q   <= 1'b0;
            singleStep_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ci_q         <= ci_d;
            piLine_q     <= piLine_d;
            piFunc_q     <= piFunc_d;
            stepPrev_q   <= step_i;
            singleStep_q <= singleStep_d;
        end
    end

`ifdef BABY_DEBUG_EN
    logic [WORD_W-1:0] pi_q;
    logic [15:0]       retireCnt_q;

    // Full instruction word is kept only for observation; execution uses the decoded fields.
    always_ff @(posedge sys_clk_i) begin
        if (!rst_ni) begin
            pi_q        <= '0;
            retireCnt_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                pi_q <= ram_data_i;
            end
            if (retire && (retireCnt_q != 16'hFFFF)) begin
                retireCnt_q <= retireCnt_q + 16'd1;
            end
        end
    end

    assign acc_o        = acc_q;
    assign ci_o         = ci_q;
    assign pi_o         = pi_q;
    assign retire_o     = retire;
    assign retire_cnt_o = retireCnt_q;
`endif

endmodule

// File: tb/tb_baby_core_p.sv
// tb_baby_core_p: drives baby_core_p against a 32x32 store and an instruction-level reference model.
module tb_baby_core_p;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic        sysClk = 1'b0;
    logic        rstN;
    logic        hltExt;
    logic        stepIn;
    logic [31:0] ramRdata;
    logic [31:0] ramWdata;
    logic [4:0]  ramAddr;
    logic        ramRwEn;
    logic        stopLamp;
    logic        hltStatus;
`ifdef BABY_DEBUG_EN
    logic [31:0] accObs;
    logic [4:0]  ciObs;
    logic [31:0] piObs;
    logic        retireObs;
    logic [15:0] retireCntObs;
`endif

    always #5 sysClk = ~sysClk;

    baby_core_p #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .sys_clk_i   (sysClk),
        .rst_ni      (rstN),
        .hlt_ext_i   (hltExt),
        .step_i      (stepIn),
        .ram_data_i  (ramRdata),
        .ram_data_o  (ramWdata),
        .ram_addr_o  (ramAddr),
        .ram_rw_en_o (ramRwEn),
        .stop_lamp_o (stopLamp),
        .hlt_status_o(hltStatus)
`ifdef BABY_DEBUG_EN
        ,
        .acc_o       (accObs),
        .ci_o        (ciObs),
        .pi_o        (piObs),
        .retire_o    (retireObs),
        .retire_cnt_o(retireCntObs)
`endif
    );

    // Store with one-cycle read latency; image is copied in wholesale while loadAll is high.
    logic [31:0] store [DEPTH];
    logic [31:0] image [DEPTH];
    logic        loadAll = 1'b0;

    always @(posedge sysClk) begin
        if (loadAll) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= image[i];
        end else if (ramRwEn) begin
            store[ramAddr] <= ramWdata;
        end
        ramRdata <= store[ramAddr];
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] mA;
    logic [4:0]  mCi;
    logic [31:0] mPi;
    int          retired;
    bit          mStopped;
    bit          stepMode;
    logic [4:0]  lastFetch;
    logic [4:0]  fetchLog [$];
    logic [4:0]  wrapSeq [6];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearImage();
        for (int i = 0; i < DEPTH; i++) image[i] = 32'h0;
        image[22] = 32'h1234_5678;
    endtask

    // Loads the store under reset, resets the model, and leaves the bench at the negedge of the first INC cycle.
    task automatic applyStimulus(input bit hltAtReset);
        rstN    = 1'b0;
        hltExt  = hltAtReset;
        stepIn  = 1'b0;
        loadAll = 1'b1;
        @(negedge sysClk);
        loadAll = 1'b0;
        @(negedge sysClk);
        checkOutput("rstRw", ramRwEn, 1'b0);
        checkOutput("rstAddr", ramAddr, 5'd0);
        checkOutput("rstData", ramWdata, 32'h0);
        checkOutput("rstStop", stopLamp, 1'b0);
        checkOutput("rstHlt", hltStatus, 1'b0);
`ifdef BABY_DEBUG_EN
        checkOutput("rstAcc", accObs, 32'h0);
        checkOutput("rstCi", ciObs, 5'd0);
        checkOutput("rstRetCnt", retireCntObs, 16'd0);
`endif
        for (int i = 0; i < DEPTH; i++) mdl[i] = image[i];
        mA       = 32'h0;
        mCi      = 5'd0;
        mPi      = 32'h0;
        retired  = 0;
        mStopped = 1'b0;
        stepMode = 1'b0;
        fetchLog.delete();
        rstN = 1'b1;
    endtask

    // One instruction: checks the bus every cycle and then applies the instruction to the model.
    task automatic runInstruction(input int raiseHltAt, input bit stepRandom);
        logic [4:0]  fetchAt;
        logic [31:0] pi;
        logic [31:0] m;
        logic [4:0]  s;
        logic [2:0]  f;
        bit          expHalt;
        fetchAt = mCi + 5'd1;
        pi      = mdl[fetchAt];
        s       = pi[4:0];
        f       = pi[15:13];
        m       = mdl[s];
        for (int c = 1; c <= 4; c++) begin
            @(negedge sysClk);
            if (raiseHltAt == c) hltExt = 1'b1;
            if (stepRandom) stepIn = 1'($urandom_range(0, 1));
            checkOutput("runStop", stopLamp, 1'b0);
            checkOutput("runHlt", hltStatus, 1'b0);
            if (c == 1) begin
                checkOutput("fetchAddr", ramAddr, fetchAt);
                lastFetch = ramAddr;
                fetchLog.push_back(ramAddr);
            end
            if (c == 3) checkOutput("operandAddr", ramAddr, s);
            if (c == 4 && f == 3'd3) begin
                checkOutput("stoRw", ramRwEn, 1'b1);
                checkOutput("stoAddr", ramAddr, s);
                checkOutput("stoData", ramWdata, mA);
            end else begin
                checkOutput("idleRw", ramRwEn, 1'b0);
                checkOutput("idleData", ramWdata, 32'h0);
            end
`ifdef BABY_DEBUG_EN
            checkOutput("retirePulse", retireObs, (c == 4));
`endif
        end
        expHalt = hltExt || stepMode;
        mCi = fetchAt;
        mPi = pi;
        case (f)
            3'd0: mCi = m[4:0];
            3'd1: mCi = fetchAt + m[4:0];
            3'd2: mA = 32'h0 - m;
            3'd3: mdl[s] = mA;
            3'd4, 3'd5: mA = mA - m;
            3'd6: if (mA[31]) mCi = fetchAt + 5'd1;
            default: mStopped = 1'b1;
        endcase
        retired++;
        @(negedge sysClk);
        checkOutput("afterStop", stopLamp, mStopped);
        checkOutput("afterHlt", hltStatus, !mStopped && expHalt);
        checkOutput("afterRw", ramRwEn, 1'b0);
`ifdef BABY_DEBUG_EN
        checkOutput("dbgAcc", accObs, mA);
        checkOutput("dbgCi", ciObs, mCi);
        checkOutput("dbgPi", piObs, mPi);
        checkOutput("dbgRetCnt", retireCntObs, retired);
`endif
    endtask

    task automatic runProgram(input int maxInstr, input bit stepRandom);
        for (int k = 0; k < maxInstr && !mStopped; k++) runInstruction(0, stepRandom);
        if (mStopped) begin
            repeat (2) begin
                @(negedge sysClk);
                stepIn = ~stepIn;
                checkOutput("stopHeld", stopLamp, 1'b1);
                checkOutput("stopRw", ramRwEn, 1'b0);
            end
        end
    endtask

    task automatic compareStore();
        for (int i = 0; i < DEPTH; i++) checkOutput($sformatf("store%0d", i), store[i], mdl[i]);
    endtask

    task automatic holdHalt(input int n);
        repeat (n) begin
            @(negedge sysClk);
            checkOutput("haltStatus", hltStatus, 1'b1);
            checkOutput("haltRw", ramRwEn, 1'b0);
            checkOutput("haltData", ramWdata, 32'h0);
            checkOutput("haltStop", stopLamp, 1'b0);
        end
    endtask

    task automatic doStep();
        stepIn = 1'b1;
        @(negedge sysClk);
        stepIn   = 1'b0;
        stepMode = 1'b1;
        runInstruction(0, 1'b0);
        stepMode = 1'b0;
    endtask

    task automatic loadProgramOne();
        clearImage();
        image[1]  = 32'h0000_4014;
        image[2]  = 32'h0000_8015;
        image[3]  = 32'h0000_6016;
        image[4]  = 32'h0000_E000;
        image[20] = 32'd3;
        image[21] = 32'd4;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN   = 1'b0;
        hltExt = 1'b0;
        stepIn = 1'b0;
        clearImage();

        // LDN/SUB/STO/STP: stop lamp 20 cycles after release, one write to line 22.
        loadProgramOne();
        applyStimulus(1'b0);
        runProgram(10, 1'b0);
        checkOutput("p1Result", store[22], 32'hFFFF_FFF9);
        checkOutput("p1LastFetch", lastFetch, 5'd4);
        compareStore();

        // CMP with negative accumulator skips line 3.
        clearImage();
        image[1]  = 32'h0000_4014;
        image[2]  = 32'h0000_C000;
        image[3]  = 32'h0000_E000;
        image[4]  = 32'h0000_6016;
        image[5]  = 32'h0000_E000;
        image[20] = 32'd1;
        applyStimulus(1'b0);
        runProgram(10, 1'b0);
        checkOutput("cmpSkipStore", store[22], 32'hFFFF_FFFF);
        checkOutput("cmpSkipLast", lastFetch, 5'd5);

        // CMP with zero accumulator falls through to STP at line 3.
        image[20] = 32'd0;
        applyStimulus(1'b0);
        runProgram(10, 1'b0);
        checkOutput("cmpNoSkipStore", store[22], 32'h1234_5678);
        checkOutput("cmpNoSkipLast", lastFetch, 5'd3);

        // JMP to 30 lands on STP at line 31.
        clearImage();
        image[1]  = 32'h0000_001E;
        image[30] = 32'd30;
        image[31] = 32'h0000_E000;
        applyStimulus(1'b0);
        runProgram(10, 1'b0);
        checkOutput("jmpLast", lastFetch, 5'd31);
        checkOutput("jmpStop", stopLamp, 1'b1);

        // CI wraps 31 -> 0 in INC, then a jump back to 0 resumes at line 1.
        image[31] = 32'h0000_001D;
        image[29] = 32'd31;
        image[0]  = 32'h0000_001C;
        image[28] = 32'd0;
        wrapSeq   = '{5'd1, 5'd31, 5'd0, 5'd1, 5'd31, 5'd0};
        applyStimulus(1'b0);
        runProgram(6, 1'b0);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("wrapFetch%0d", i), fetchLog[i], wrapSeq[i]);

        // Halt held from reset: first instruction runs, then single steps; STP under step enters STOP.
        loadProgramOne();
        applyStimulus(1'b1);
        runInstruction(0, 1'b0);
        holdHalt(3);
        doStep();
        holdHalt(2);
        doStep();
        holdHalt(1);
        doStep();
        runProgram(1, 1'b0);
        checkOutput("stepStop", stopLamp, 1'b1);
        checkOutput("stepHlt", hltStatus, 1'b0);
        checkOutput("stepResult", store[22], 32'hFFFF_FFF9);

        // Looping program: steps, release with a step edge (ignored), then a mid-instruction halt.
        clearImage();
        image[1]  = 32'h0000_4014;
        image[2]  = 32'h0000_8015;
        image[3]  = 32'h0000_6016;
        image[4]  = 32'h0000_0017;
        image[20] = 32'd3;
        image[21] = 32'd4;
        image[23] = 32'd0;
        applyStimulus(1'b1);
        runInstruction(0, 1'b0);
        holdHalt(2);
        doStep();
        doStep();
        hltExt = 1'b0;
        stepIn = 1'b1;
        @(negedge sysClk);
        stepIn = 1'b0;
        runInstruction(0, 1'b0);
        runInstruction(0, 1'b1);
        stepIn = 1'b0;
        runInstruction(2, 1'b0);
        holdHalt(3);
        hltExt = 1'b0;
        @(negedge sysClk);
        runProgram(3, 1'b0);
        compareStore();

        // Reset during the EXEC cycle of STO aborts the write and restarts from line 1.
        loadProgramOne();
        applyStimulus(1'b0);
        runInstruction(0, 1'b0);
        runInstruction(0, 1'b0);
        repeat (4) @(negedge sysClk);
        checkOutput("preRstRw", ramRwEn, 1'b1);
        checkOutput("preRstAddr", ramAddr, 5'd22);
        rstN = 1'b0;
        @(negedge sysClk);
        checkOutput("postRstRw", ramRwEn, 1'b0);
        checkOutput("postRstData", ramWdata, 32'h0);
        checkOutput("abortedWrite", store[22], 32'h1234_5678);
`ifdef BABY_DEBUG_EN
        checkOutput("postRstCi", ciObs, 5'd0);
        checkOutput("postRstAcc", accObs, 32'h0);
`endif
        mA       = 32'h0;
        mCi      = 5'd0;
        retired  = 0;
        mStopped = 1'b0;
        rstN     = 1'b1;
        runProgram(10, 1'b0);
        checkOutput("restartResult", store[22], 32'hFFFF_FFF9);

        // Random store contents, with step_i toggling while running (must be ignored).
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) image[i] = $urandom;
            applyStimulus(1'b0);
            runProgram(40, 1'b1);
            compareStore();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
